// File: rtl/mux_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_ctrl_pkg
// Description : Shared definitions for the design-mux configuration
//               sequencer: handover FSM state encoding, default slot
//               geometry and the range-masked selection decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_ctrl_pkg;

    // Default selection field width and number of design slots.
    localparam int MUX_SEL_W       = 4;
    localparam int MUX_NUM_DESIGNS = 8;

    // Handover FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRE    = 2'd1,
        ST_SWITCH = 2'd2,
        ST_POST   = 2'd3
    } mux_state_t;

    // One bit of the one-hot decode of a selection. Selections at or beyond
    // num_slots address "no design" and therefore never hit any slot, so a
    // loop over all slots yields a range-masked one-hot vector.
    function automatic logic sel_hits_slot(
        input logic [31:0] sel,
        input int          slot,
        input int          num_slots
    );
        return (sel < 32'(num_slots)) && (sel == 32'(slot));
    endfunction

endpackage : mux_ctrl_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for a group of level signals with a
//               programmable asynchronous reset value.
// Ports       : clk_i  - destination clock
//               rst_i  - asynchronous active-high reset
//               d_i    - asynchronous input bus
//               q_o    - synchronised output bus (2 cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/mux_conf_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mux_conf_sequencer
// Description : Captures design selections from an asynchronous LA strobe
//               and switches the design mux with a reset-isolated handover.
//               Manual, auto-sequenced and system resets are merged into a
//               registered per-design reset vector.
// Ports       : wb_clk_i         - block clock
//               wb_rst_i         - asynchronous active-high reset
//               i_conf_clk       - LA configuration strobe (asynchronous)
//               i_sel            - requested selection, taken on strobe edge
//               i_design_reset   - manual per-design reset (asynchronous)
//               i_auto_reset_enb - 0 enables the sequenced handover
//               i_sys_reset_enb  - 0 lets wb_rst_i reset the designs
//               o_mux_sel        - registered mux selection
//               o_design_rst     - registered per-design reset, active-high
//               o_busy           - handover in progress
//               o_sel_done       - one-cycle pulse when a request completes
// Revision    : 1.0 - initial release
// ============================================================================
module mux_conf_sequencer
    import mux_ctrl_pkg::*;
#(
    parameter int NUM_DESIGNS = MUX_NUM_DESIGNS,
    parameter int SEL_W       = MUX_SEL_W,
    parameter int DEFAULT_SEL = 0,
    parameter int PRE_CYCLES  = 4,
    parameter int POST_CYCLES = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   i_conf_clk,
    input  logic [SEL_W-1:0]       i_sel,
    input  logic [NUM_DESIGNS-1:0] i_design_reset,
    input  logic                   i_auto_reset_enb,
    input  logic                   i_sys_reset_enb,
    output logic [SEL_W-1:0]       o_mux_sel,
    output logic [NUM_DESIGNS-1:0] o_design_rst,
    output logic                   o_busy,
    output logic                   o_sel_done
);

    // Counter sized for the longer of the two hold phases (min 1 bit).
    localparam int c_cnt_max = (PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    localparam logic [SEL_W-1:0]   c_default_sel = SEL_W'(DEFAULT_SEL);
    localparam logic [c_cnt_w-1:0] c_pre_load    = c_cnt_w'(PRE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_post_load   = c_cnt_w'(POST_CYCLES - 1);

    // ------------------------------------------------------------------
    // Input synchronisation
    // ------------------------------------------------------------------
    logic                   w_strobe_s;
    logic                   strobe_prev_q;
    logic                   w_strobe_edge;
    logic [SEL_W-1:0]       w_sel_s;
    logic [NUM_DESIGNS-1:0] w_design_reset_s;
    logic [1:0]             w_enb_s;
    logic                   w_auto_reset_enb_s;
    logic                   w_sys_reset_enb_s;

    // Strobe flops reset high so a strobe already high at reset release
    // is not mistaken for a fresh rising edge.
    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync_strobe (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   (i_conf_clk),
        .q_o   (w_strobe_s)
    );

    sync_2ff #(
        .WIDTH   (SEL_W),
        .RST_VAL (c_default_sel)
    ) u_sync_sel (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   (i_sel),
        .q_o   (w_sel_s)
    );

    sync_2ff #(
        .WIDTH   (NUM_DESIGNS),
        .RST_VAL ('0)
    ) u_sync_design_reset (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   (i_design_reset),
        .q_o   (w_design_reset_s)
    );

    // Both enables reset to "disabled" until real values have been sampled.
    sync_2ff #(
        .WIDTH   (2),
        .RST_VAL (2'b11)
    ) u_sync_enables (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   ({i_auto_reset_enb, i_sys_reset_enb}),
        .q_o   (w_enb_s)
    );

    assign w_auto_reset_enb_s = w_enb_s[1];
    assign w_sys_reset_enb_s  = w_enb_s[0];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            strobe_prev_q <= 1'b1;
        end else begin
            strobe_prev_q <= w_strobe_s;
        end
    end

    assign w_strobe_edge = w_strobe_s & ~strobe_prev_q;

    // ------------------------------------------------------------------
    // Handover FSM and datapath
    // ------------------------------------------------------------------
    mux_state_t             state_q,      state_d;
    logic [c_cnt_w-1:0]     cnt_q,        cnt_d;
    logic [SEL_W-1:0]       pend_sel_q,   pend_sel_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [SEL_W-1:0]       old_sel_q,    old_sel_d;
    logic [SEL_W-1:0]       new_sel_q,    new_sel_d;
    logic [SEL_W-1:0]       mux_sel_q,    mux_sel_d;
    logic                   sel_done_q,   sel_done_d;
    logic [NUM_DESIGNS-1:0] design_rst_q, design_rst_d;

    logic [NUM_DESIGNS-1:0] w_old_hot;
    logic [NUM_DESIGNS-1:0] w_new_hot;
    logic [NUM_DESIGNS-1:0] w_auto_rst;
    logic                   w_busy;

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_sel_d   = pend_sel_q;
        pend_valid_d = pend_valid_q;
        old_sel_d    = old_sel_q;
        new_sel_d    = new_sel_q;
        mux_sel_d    = mux_sel_q;
        sel_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) begin
                    pend_valid_d = 1'b0;
                    if (pend_sel_q == mux_sel_q) begin
                        sel_done_d = 1'b1;
                    end else if (w_auto_reset_enb_s) begin
                        // Auto-reset disabled: switch immediately.
                        mux_sel_d  = pend_sel_q;
                        sel_done_d = 1'b1;
                    end else begin
                        state_d   = ST_PRE;
                        cnt_d     = c_pre_load;
                        old_sel_d = mux_sel_q;
                        new_sel_d = pend_sel_q;
                    end
                end
            end
            ST_PRE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SWITCH;
                end else begin
                    cnt_d = cnt_q - c_cnt_w'(1);
                end
            end
            ST_SWITCH: begin
                mux_sel_d = new_sel_q;
                cnt_d     = c_post_load;
                state_d   = ST_POST;
            end
            ST_POST: begin
                if (cnt_q == '0) begin
                    state_d    = ST_IDLE;
                    sel_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - c_cnt_w'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new strobe always wins over consumption of the previous one,
        // giving a one-deep, newest-wins request slot.
        if (w_strobe_edge) begin
            pend_sel_d   = w_sel_s;
            pend_valid_d = 1'b1;
        end
    end

    // FSM outputs: busy flag and auto-reset contribution
    always_comb begin
        w_old_hot  = '0;
        w_new_hot  = '0;
        w_auto_rst = '0;
        for (int i = 0; i < NUM_DESIGNS; i++) begin
            w_old_hot[i] = sel_hits_slot(32'(old_sel_q), i, NUM_DESIGNS);
            w_new_hot[i] = sel_hits_slot(32'(new_sel_q), i, NUM_DESIGNS);
        end
        case (state_q)
            ST_PRE:              w_auto_rst = w_old_hot | w_new_hot;
            ST_SWITCH, ST_POST:  w_auto_rst = w_new_hot;
            default:             w_auto_rst = '0;
        endcase
        w_busy = (state_q != ST_IDLE);
    end

    // The wb_rst_i term only matters while reset is asserted, where the
    // asynchronous reset value of all ones already covers it.
    assign design_rst_d = w_design_reset_s
                        | w_auto_rst
                        | {NUM_DESIGNS{~w_sys_reset_enb_s & wb_rst_i}};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q        <= '0;
            pend_sel_q   <= c_default_sel;
            pend_valid_q <= 1'b0;
            old_sel_q    <= c_default_sel;
            new_sel_q    <= c_default_sel;
            mux_sel_q    <= c_default_sel;
            sel_done_q   <= 1'b0;
            design_rst_q <= '1;
        end else begin
            cnt_q        <= cnt_d;
            pend_sel_q   <= pend_sel_d;
            pend_valid_q <= pend_valid_d;
            old_sel_q    <= old_sel_d;
            new_sel_q    <= new_sel_d;
            mux_sel_q    <= mux_sel_d;
            sel_done_q   <= sel_done_d;
            design_rst_q <= design_rst_d;
        end
    end

    assign o_mux_sel    = mux_sel_q;
    assign o_design_rst = design_rst_q;
    assign o_busy       = w_busy;
    assign o_sel_done   = sel_done_q;

endmodule : mux_conf_sequencer
`default_nettype wire

// File: doc/mux_conf_sequencer.md
Name: mux_conf_sequencer

Overview:
- Sits directly upstream of top_design_mux, between the raw LA control bits and the mux's select/reset inputs.
- Synchronises the LA-driven configuration strobe into wb_clk_i and captures a new design selection on each strobe.
- On a selection change, runs a reset-isolated handover: the outgoing and incoming designs are held in reset around the select switch.
- Merges manual per-design resets with the auto-reset and system-reset contributions into one registered reset vector per design.

Parameters:
- NUM_DESIGNS, 8, number of design slots; sel values >= NUM_DESIGNS mean "no design".
- SEL_W, 4, width of the selection field.
- DEFAULT_SEL, 0, selection loaded at reset.
- PRE_CYCLES, 4, cycles both designs are held in reset before the select switch.
- POST_CYCLES, 8, cycles the new design is held in reset after the switch.

Ports:
- wb_clk_i  in  1  single clock for the block.
- wb_rst_i  in  1  asynchronous, active-high reset.
- i_conf_clk  in  1  LA configuration strobe; asynchronous to wb_clk_i.
- i_sel  in  SEL_W  requested design selection; sampled only on a strobe rising edge.
- i_design_reset  in  NUM_DESIGNS  manual per-design reset from LA; level, asynchronous.
- i_auto_reset_enb  in  1  0 = sequenced auto-reset enabled.
- i_sys_reset_enb  in  1  0 = wb_rst_i also resets the designs.
- o_mux_sel  out  SEL_W  registered selection driven to top_design_mux.
- o_design_rst  out  NUM_DESIGNS  registered per-design reset, active-high.
- o_busy  out  1  high while the handover FSM is not in IDLE.
- o_sel_done  out  1  one-cycle pulse when a handover completes.

Behaviour:
- Async reset (wb_rst_i=1):
  - o_mux_sel=DEFAULT_SEL, o_design_rst=all ones, o_busy=0, o_sel_done=0.
  - FSM=IDLE, pending flag cleared.
  - Synchroniser flops set to 1, so a strobe already high at reset release does not count as an edge.
- Synchronisation:
  - i_conf_clk passes through a 2-FF synchroniser plus an edge register.
  - A strobe rising edge is seen 3 cycles after the pin edge.
  - i_sel, i_design_reset, i_auto_reset_enb and i_sys_reset_enb each pass through 2-FF synchronisers.
  - i_sel is captured from its synchronised copy in the edge cycle.
- Strobe capture:
  - An edge always loads pend_sel and sets pend_valid.
  - A later edge before pend_valid is consumed overwrites pend_sel (one-deep, newest wins).
- FSM states: IDLE, PRE, SWITCH, POST.
  - IDLE: if pend_valid, clear it.
    - If pend_sel == o_mux_sel: no handover, o_sel_done pulses next cycle.
    - Else if auto-reset is disabled (i_auto_reset_enb=1): load o_mux_sel directly and pulse o_sel_done; stay in IDLE.
    - Else: go to PRE and load cnt=PRE_CYCLES-1.
  - PRE: auto_rst bit set for old_sel and new_sel. Decrement cnt; at cnt==0 go to SWITCH.
  - SWITCH: exactly 1 cycle. o_mux_sel<=new_sel. Load cnt=POST_CYCLES-1, go to POST.
  - POST: auto_rst is set for new_sel only. At cnt==0 go to IDLE and pulse o_sel_done.
  - o_busy=1 in PRE, SWITCH and POST.
  - A strobe arriving during a handover sets pend_valid and is processed on the return to IDLE.
- Reset merge, registered with 1 cycle latency from the synchronised inputs:
  - o_design_rst[i] = design_reset_s[i] | auto_rst[i] | (~sys_reset_enb_s & wb_rst_i).
  - The wb_rst_i term is only visible while in reset, so it is covered by the async reset value of all ones.
- Out-of-range selections:
  - Slot indices >= NUM_DESIGNS contribute no auto_rst bit.
  - o_mux_sel is still updated with the raw value.
- Counter width is clog2(max(PRE_CYCLES,POST_CYCLES)). Both PRE_CYCLES and POST_CYCLES must be >= 1.
- Reset mid-handover returns everything to the reset values above. The pending selection is lost.

Decomposition:
- Shared package mux_ctrl_pkg: FSM state enum, SEL_W, NUM_DESIGNS, and a function that one-hot decodes a sel with range masking.
- Sub-module sync_2ff (parameterised width, reset value): instantiated for the strobe and for each level input group.

Test Plan:
- Reset, then release with i_conf_clk=1 -> no capture; o_mux_sel=0 and o_design_rst=8'hFF during reset. After release, o_design_rst follows i_design_reset (with 3-cycle sync+register latency).
- i_auto_reset_enb=0, strobe with i_sel=3 from sel 0:
  - o_design_rst bits 0 and 3 high for 4 cycles.
  - o_mux_sel=3 on the SWITCH cycle, then bit 3 high for 8 more cycles.
  - o_sel_done pulses once; o_busy is high for exactly 13 cycles.
- i_auto_reset_enb=1, strobe with sel=5 -> o_mux_sel=5 within 5 cycles of the pin edge, no auto-reset bits, o_busy stays 0.
- Strobes for sel=2, then 6, then 7 during one handover -> after the first handover, exactly one more handover, to 7; 6 is never driven.
- Strobe with sel=12 (out of range) -> only the old slot is auto-reset; o_mux_sel=12. Separately, strobe with sel equal to the current sel -> o_busy stays 0 and o_sel_done pulses.
- Assert wb_rst_i during POST -> immediate o_mux_sel=DEFAULT_SEL, o_design_rst=all ones, o_busy=0. Separately, i_sys_reset_enb=0 with i_design_reset=0 -> all bits high only while wb_rst_i=1.
